// File: rtl/proc_pkg.sv
// Shared definitions for the processing block and its output-path drain logic.
package proc_pkg;

    localparam int DATA_WIDTH     = 32;
    localparam int BYTES_PER_WORD = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } drain_state_t;

endpackage

// File: rtl/proc_skid_buf.sv
// Two-entry, order-preserving output buffer between the FIFO read path and the
// master port. Head entry drives the outputs directly from registers.
module proc_skid_buf
    import proc_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  ready,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] data,
    output logic [1:0]            occ
);

    logic [DATA_WIDTH-1:0] head_r, tail_r;
    logic [DATA_WIDTH-1:0] head_nxt_s, tail_nxt_s;
    logic [1:0]            occ_r, occ_nxt_s;
    logic                  valid_r;
    logic                  pop_s;

    assign pop_s = valid_r & ready;

    // Next buffer contents: head always holds the oldest word.
    always_comb begin
        head_nxt_s = head_r;
        tail_nxt_s = tail_r;
        occ_nxt_s  = occ_r;
        case ({push, pop_s})
            2'b10: begin
                if (occ_r == 2'd0) begin
                    head_nxt_s = push_data;
                    occ_nxt_s  = 2'd1;
                end else if (occ_r == 2'd1) begin
                    tail_nxt_s = push_data;
                    occ_nxt_s  = 2'd2;
                end else begin
                    occ_nxt_s  = occ_r;
                end
            end
            2'b01: begin
                head_nxt_s = tail_r;
                occ_nxt_s  = occ_r - 2'd1;
            end
            2'b11: begin
                if (occ_r == 2'd2) begin
                    head_nxt_s = tail_r;
                    tail_nxt_s = push_data;
                end else begin
                    head_nxt_s = push_data;
                end
            end
            default: begin
                occ_nxt_s = occ_r;
            end
        endcase
    end

    // Buffer registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_r  <= {DATA_WIDTH{1'b0}};
            tail_r  <= {DATA_WIDTH{1'b0}};
            occ_r   <= 2'd0;
            valid_r <= 1'b0;
        end else begin
            head_r  <= head_nxt_s;
            tail_r  <= tail_nxt_s;
            occ_r   <= occ_nxt_s;
            valid_r <= (occ_nxt_s != 2'd0);
        end
    end

    assign valid = valid_r;
    assign data  = head_r;
    assign occ   = occ_r;

endmodule

// File: rtl/proc_mstr_drain.sv
// Drains the processing block's output FIFO onto the master write port,
// generating word addresses and burst-last markers and reporting underflow.
module proc_mstr_drain
    import proc_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int CNT_WIDTH  = 20,
    parameter int BURST_LEN  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [CNT_WIDTH-1:0]  num_words,
    input  logic                  fifo_empty,
    output logic                  fifo_rd,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    input  logic                  proc_cmplt,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [ADDR_WIDTH-1:0] m_addr,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic                  busy,
    output logic                  done,
    output logic                  err_underflow
);

    localparam int BC_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BC_W-1:0] BURST_MAX = BC_W'(BURST_LEN - 1);

    drain_state_t          state_r, state_nxt_s;
    logic [CNT_WIDTH-1:0]  num_words_r, issued_r, sent_r;
    logic [BC_W-1:0]       burst_cnt_r, burst_nxt_s;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic                  last_r, inflight_r, cmplt_seen_r, uflow_r;
    logic                  err_r, busy_r, done_r;
    logic [1:0]            occ_s;
    logic                  pop_s, room_s, fifo_rd_s, start_ok_s;
    logic                  uflow_trig_s, uflow_any_s, final_pop_s;

    proc_skid_buf u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (inflight_r),
        .push_data (fifo_data),
        .ready     (m_ready),
        .valid     (m_valid),
        .data      (m_data),
        .occ       (occ_s)
    );

    assign pop_s       = m_valid & m_ready;
    // Buffer space counting the word still in flight and the one leaving now.
    assign room_s      = ({1'b0, occ_s} + {2'b00, inflight_r}) < (3'd2 + {2'b00, pop_s});
    assign fifo_rd_s   = (state_r == RUN) & ~fifo_empty & (issued_r < num_words_r)
                       & room_s & ~uflow_r;
    assign start_ok_s  = (state_r == IDLE) & start;
    // Producer finished while words are still owed and nothing is coming.
    assign uflow_trig_s = (state_r == RUN) & (cmplt_seen_r | proc_cmplt) & fifo_empty
                        & (issued_r < num_words_r) & ~inflight_r & ~uflow_r;
    assign uflow_any_s = uflow_r | uflow_trig_s;
    assign final_pop_s = pop_s & ((sent_r + CNT_WIDTH'(1)) == num_words_r);
    assign burst_nxt_s = (burst_cnt_r == BURST_MAX) ? {BC_W{1'b0}} : burst_cnt_r + BC_W'(1);

    // Frame sequencing: leave RUN on the final handshake or once an underflowed frame has drained.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nxt_s = (num_words == {CNT_WIDTH{1'b0}}) ? DONE : RUN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                if (final_pop_s) begin
                    state_nxt_s = DONE;
                end else if (uflow_any_s && (occ_s == 2'd0) && !inflight_r) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // State, counters, address/last generation and status flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            num_words_r  <= {CNT_WIDTH{1'b0}};
            issued_r     <= {CNT_WIDTH{1'b0}};
            sent_r       <= {CNT_WIDTH{1'b0}};
            burst_cnt_r  <= {BC_W{1'b0}};
            addr_r       <= {ADDR_WIDTH{1'b0}};
            last_r       <= 1'b0;
            inflight_r   <= 1'b0;
            cmplt_seen_r <= 1'b0;
            uflow_r      <= 1'b0;
            err_r        <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            busy_r     <= (state_nxt_s == RUN);
            done_r     <= (state_nxt_s == DONE);
            inflight_r <= fifo_rd_s;
            if (start_ok_s) begin
                num_words_r  <= num_words;
                issued_r     <= {CNT_WIDTH{1'b0}};
                sent_r       <= {CNT_WIDTH{1'b0}};
                burst_cnt_r  <= {BC_W{1'b0}};
                addr_r       <= base_addr;
                last_r       <= (BURST_MAX == {BC_W{1'b0}}) | (num_words == CNT_WIDTH'(1));
                cmplt_seen_r <= 1'b0;
                uflow_r      <= 1'b0;
                err_r        <= 1'b0;
            end else begin
                if (fifo_rd_s) begin
                    issued_r <= issued_r + CNT_WIDTH'(1);
                end
                if (pop_s) begin
                    sent_r      <= sent_r + CNT_WIDTH'(1);
                    addr_r      <= addr_r + ADDR_WIDTH'(BYTES_PER_WORD);
                    burst_cnt_r <= burst_nxt_s;
                    last_r      <= (burst_nxt_s == BURST_MAX)
                                 | ((sent_r + CNT_WIDTH'(2)) == num_words_r);
                end
                if ((state_r == RUN) && proc_cmplt) begin
                    cmplt_seen_r <= 1'b1;
                end
                if (uflow_trig_s) begin
                    uflow_r <= 1'b1;
                    err_r   <= 1'b1;
                end
            end
        end
    end

    assign fifo_rd       = fifo_rd_s;
    assign m_addr        = addr_r;
    assign m_last        = last_r;
    assign busy          = busy_r;
    assign done          = done_r;
    assign err_underflow = err_r;

endmodule

// File: tb/tb_proc_mstr_drain.sv
// Scoreboard bench for proc_mstr_drain: a behavioural FIFO feeds the DUT,
// expected master words are queued at stimulus time and checked by a monitor.
module tb_proc_mstr_drain;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] base_addr;
    logic [19:0] num_words;
    logic        fifo_empty;
    logic        fifo_rd;
    logic [31:0] fifo_data;
    logic        proc_cmplt;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_addr;
    logic [31:0] m_data;
    logic        m_last;
    logic        busy;
    logic        done;
    logic        err_underflow;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        last;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] fifo_mem [0:63];
    int          wr_ptr, rd_ptr;
    logic        flush;
    int          tests, fails;
    int          cyc, rd_cnt, rd_empty_err, rd_idle_err;
    int          hs_cnt, done_cnt, last_hs_cyc, done_cyc, start_cyc, max_out;
    logic        track_out;
    logic        prev_stall, prev_last;
    logic [31:0] prev_data, prev_addr;

    proc_mstr_drain dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .base_addr     (base_addr),
        .num_words     (num_words),
        .fifo_empty    (fifo_empty),
        .fifo_rd       (fifo_rd),
        .fifo_data     (fifo_data),
        .proc_cmplt    (proc_cmplt),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_addr        (m_addr),
        .m_data        (m_data),
        .m_last        (m_last),
        .busy          (busy),
        .done          (done),
        .err_underflow (err_underflow)
    );

    always #5 clk = ~clk;

    assign fifo_empty = (wr_ptr == rd_ptr);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Cycle counter.
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural output FIFO: read data appears one cycle after fifo_rd.
    always @(posedge clk) begin
        if (flush) begin
            rd_ptr <= wr_ptr;
        end else if (fifo_rd) begin
            if (fifo_empty) begin
                rd_empty_err <= rd_empty_err + 1;
            end else begin
                fifo_data <= fifo_mem[rd_ptr % 64];
                rd_ptr    <= rd_ptr + 1;
                rd_cnt    <= rd_cnt + 1;
            end
            if (!busy) rd_idle_err <= rd_idle_err + 1;
        end
    end

    // Monitor: scoreboard compare on handshakes, stall stability, done tracking.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", {63'd0, m_valid}, 64'd1);
                check("stall_data", {32'd0, m_data}, {32'd0, prev_data});
                check("stall_addr", {32'd0, m_addr}, {32'd0, prev_addr});
                check("stall_last", {63'd0, m_last}, {63'd0, prev_last});
            end
            if (m_valid && m_ready) begin
                hs_cnt++;
                last_hs_cyc = cyc;
                if (exp_q.size() == 0) begin
                    check("unexpected_word", {32'd0, m_data}, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("word_data", {32'd0, m_data}, {32'd0, e.data});
                    check("word_addr", {32'd0, m_addr}, {32'd0, e.addr});
                    check("word_last", {63'd0, m_last}, {63'd0, e.last});
                end
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (track_out && (rd_cnt - hs_cnt > max_out)) max_out = rd_cnt - hs_cnt;
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_addr  = m_addr;
            prev_last  = m_last;
        end
    end

    task automatic check_idle_outputs(input string tag);
        check({tag, "_m_valid"}, {63'd0, m_valid}, 64'd0);
        check({tag, "_fifo_rd"}, {63'd0, fifo_rd}, 64'd0);
        check({tag, "_busy"}, {63'd0, busy}, 64'd0);
        check({tag, "_done"}, {63'd0, done}, 64'd0);
        check({tag, "_err"}, {63'd0, err_underflow}, 64'd0);
        check({tag, "_m_addr"}, {32'd0, m_addr}, 64'd0);
        check({tag, "_m_data"}, {32'd0, m_data}, 64'd0);
        check({tag, "_m_last"}, {63'd0, m_last}, 64'd0);
    endtask

    // One frame: preload FIFO, queue expectations, start, run until done or budget.
    task automatic run_frame(input logic [31:0] base, input int n, input int nfill,
                             input bit toggle, input int cmplt_at, input int restart_at,
                             input int rst_after, input bit exp_err);
        int rd0, hs0, d0, nexp;
        bit was_reset;
        rd0 = rd_cnt; hs0 = hs_cnt; d0 = done_cnt;
        was_reset = 1'b0;
        nexp = (n < nfill) ? n : nfill;
        for (int i = 0; i < nfill; i++) begin
            logic [31:0] d;
            exp_t e;
            d = base ^ {8'hC3, 8'(i), 16'(i * 3 + 1)};
            fifo_mem[wr_ptr % 64] = d;
            wr_ptr++;
            if (i < n) begin
                e.addr = base + 32'(i * 4);
                e.data = d;
                e.last = (((i + 1) % 16) == 0) || ((i + 1) == n);
                exp_q.push_back(e);
            end
        end
        @(posedge clk); #1;
        start = 1'b1; base_addr = base; num_words = 20'(n); start_cyc = cyc; m_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 300; k++) begin
            if (done_cnt != d0) break;
            if (rst_after >= 0 && (hs_cnt - hs0) >= rst_after) begin
                m_ready = 1'b0; rst_n = 1'b0;
                @(posedge clk); #1;
                check_idle_outputs("midreset");
                rst_n = 1'b1; flush = 1'b1;
                @(posedge clk); #1;
                flush = 1'b0;
                exp_q.delete();
                was_reset = 1'b1;
                break;
            end
            m_ready    = toggle ? ~m_ready : 1'b1;
            proc_cmplt = (k == cmplt_at);
            if (k == restart_at) begin
                start = 1'b1; base_addr = 32'hDEAD_0000; num_words = 20'd3;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
        end
        start = 1'b0; proc_cmplt = 1'b0; m_ready = 1'b1;
        if (!was_reset) begin
            repeat (3) @(posedge clk);
            #1;
            check("done_pulses", 64'(done_cnt - d0), 64'd1);
            check("sb_empty", 64'(exp_q.size()), 64'd0);
            check("rd_count", 64'(rd_cnt - rd0), 64'(nexp));
            check("hs_count", 64'(hs_cnt - hs0), 64'(nexp));
            check("err_underflow", {63'd0, err_underflow}, {63'd0, exp_err});
            if (n == 0) check("done_lat_zero", 64'(done_cyc - start_cyc), 64'd1);
            else if (cmplt_at < 0) check("done_lat", 64'(done_cyc - last_hs_cyc), 64'd1);
            exp_q.delete();
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; base_addr = 32'd0; num_words = 20'd0;
        proc_cmplt = 1'b0; m_ready = 1'b1; flush = 1'b0; track_out = 1'b0;
        max_out = 0; prev_stall = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        rst_n = 1'b1;

        // Streaming, full rate.
        run_frame(32'h0000_1000, 5, 5, 1'b0, -1, -1, -1, 1'b0);
        // Backpressure with an ignored start mid-frame.
        track_out = 1'b1;
        run_frame(32'h0000_2000, 8, 8, 1'b1, -1, 4, -1, 1'b0);
        track_out = 1'b0;
        check("max_outstanding_le3", {63'd0, (max_out <= 3)}, 64'd1);
        // Bursts across an address wrap.
        run_frame(32'hFFFF_FFC0, 20, 20, 1'b0, -1, -1, -1, 1'b0);
        // Underflow: 4 of 6 words, then producer completes.
        run_frame(32'h0000_4000, 6, 4, 1'b0, 12, -1, -1, 1'b1);
        // Zero-length frame (also clears the sticky underflow).
        run_frame(32'h0000_5000, 0, 0, 1'b0, -1, -1, -1, 1'b0);
        // Reset after 3 of 10 words, then a clean frame.
        run_frame(32'h0000_5000, 10, 10, 1'b0, -1, -1, 3, 1'b0);
        run_frame(32'h0000_6000, 4, 4, 1'b0, -1, -1, -1, 1'b0);

        check("rd_while_empty", 64'(rd_empty_err), 64'd0);
        check("rd_outside_run", 64'(rd_idle_err), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/proc_mstr_drain.md
Name: proc_mstr_drain

Overview:
- Reader side of the processing block's output path.
- The processing block pushes results into the output FIFO with wr/data_out and pulses mstr_data_cmplt.
- This block pops that FIFO and streams each word to the master write port with a valid/ready handshake, generating addresses and burst-last markers.
- It reports frame completion, or underflow if the processing block finishes early.

Parameters:
- DATA_WIDTH, 32, FIFO word and master data width (shared package constant).
- ADDR_WIDTH, 32, master address width.
- CNT_WIDTH, 20, width of the frame word counter.
- BURST_LEN, 16, words per burst; m_last is asserted on every BURST_LEN-th word.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  one-cycle frame start pulse; ignored unless IDLE.
- base_addr  in  ADDR_WIDTH  byte address of the first word; sampled on start.
- num_words  in  CNT_WIDTH  words in the frame; sampled on start.
- fifo_empty  in  1  output FIFO empty flag.
- fifo_rd  out  1  FIFO pop request.
- fifo_data  in  DATA_WIDTH  FIFO read data, valid exactly 1 cycle after fifo_rd.
- proc_cmplt  in  1  mstr_data_cmplt from the processing block, one-cycle pulse.
- m_valid  out  1  master word valid.
- m_ready  in  1  master accepts word.
- m_addr  out  ADDR_WIDTH  byte address of the current word.
- m_data  out  DATA_WIDTH  current word.
- m_last  out  1  last word of a burst or of the frame.
- busy  out  1  high in RUN.
- done  out  1  one-cycle completion pulse.
- err_underflow  out  1  sticky; cleared on the next accepted start.

Behaviour:
- Reset (rst_n low at a clk edge):
  - All outputs 0, state IDLE, buffer empty, counters 0, no read in flight.
  - Reset mid-frame abandons the frame; fifo_rd is low from the reset edge.
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN on start with num_words != 0. Latch base_addr, num_words; clear issued, sent and err_underflow.
  - IDLE -> DONE on start with num_words == 0. No reads, no transfers.
  - RUN -> DONE when sent == num_words, i.e. the cycle after the final m_valid & m_ready handshake.
  - RUN -> DONE on underflow.
  - DONE -> IDLE unconditionally after 1 cycle; done = 1 during DONE.
- Read issue:
  - fifo_rd = RUN & !fifo_empty & (issued < num_words) & (occ + inflight - pop < 2).
  - occ = valid entries in the 2-entry buffer; inflight = read issued last cycle; pop = m_valid & m_ready.
  - Write-back of fifo_data happens the cycle after fifo_rd.
  - Sustains 1 word per cycle when m_ready is held high.
- Latency: first m_valid appears 2 cycles after fifo_rd can first assert (read cycle, then data-capture cycle).
- Output rules:
  - m_valid, m_data, m_addr and m_last stay stable while m_valid & !m_ready.
  - Word order is preserved.
- Addressing: m_addr = base + sent*(DATA_WIDTH/8), modulo 2^ADDR_WIDTH; wrap-around is allowed silently.
- m_last = ((sent+1) % BURST_LEN == 0) | (sent+1 == num_words).
- Underflow:
  - Trigger: proc_cmplt seen (latched) while in RUN, fifo_empty, issued < num_words, no read in flight.
  - Effect: set err_underflow; words already in the buffer drain first; then DONE.
- proc_cmplt arriving after all words are issued is a normal completion and has no effect.
- start while not IDLE is ignored.
- fifo_rd is never asserted when fifo_empty is high, outside RUN, or once issued == num_words.

Decomposition:
- proc_pkg (shared with the processing block):
  - DATA_WIDTH constant.
  - drain_state_t enum {IDLE, RUN, DONE}.
  - BYTES_PER_WORD constant.
- Sub-module proc_skid_buf: 2-entry FIFO-ordered output buffer.
  - Inputs push/data; outputs valid/data; inputs pop/ready; reports occ.
  - Registered outputs.
- The top holds the FSM, counters, address and last generation.

Test Plan:
- Streaming: num_words=5, base 0x1000, FIFO preloaded with 5 words, m_ready=1 -> addresses 0x1000..0x1010, data in order, m_last only on word 5, done 1 cycle after the 5th handshake, 5 fifo_rd pulses total.
- Backpressure: num_words=8, m_ready toggling 1/0 every cycle -> m_valid/m_data stable while stalled, no FIFO over-read (at most 2 buffered + 1 in flight), 8 words delivered in order.
- Bursts: num_words=20, BURST_LEN=16 -> m_last on words 16 and 20.
- Underflow: num_words=6, only 4 words written, then proc_cmplt -> 4 words delivered, err_underflow=1, done pulse, no fifo_rd while empty.
- Edge cases:
  - num_words=0 -> done 1 cycle after start, no fifo_rd or m_valid.
  - start during RUN -> ignored.
- Reset mid-frame after 3 of 10 words -> next cycle all outputs 0 and state IDLE; a new start runs a clean frame from sent=0.
